// File: rtl/mips_pkg.sv
// Shared ID-stage definitions: opcodes, control-bundle layout and the
// combinational opcode decoder.
package mips_pkg;

    localparam int CTRL_W = 14;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Control bundle bit offsets; bit 13 is reserved and always 0
    localparam int CTRL_REGDST    = 0;
    localparam int CTRL_ALUSRC    = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_WBI_LO    = 3;
    localparam int CTRL_WBI_HI    = 4;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_ISEQ      = 6;
    localparam int CTRL_ISNOTCOND = 7;
    localparam int CTRL_ISJUMP    = 8;
    localparam int CTRL_ALUOP_LO  = 9;
    localparam int CTRL_ALUOP_HI  = 12;

    // ALU operation codes; ALU_FUNCT defers to the R-type funct field
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_SLT   = 4'h4;
    localparam logic [3:0] ALU_LUI   = 4'h5;
    localparam logic [3:0] ALU_FUNCT = 4'hF;

    // Write-back source select
    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_LINK = 2'b11;

    // Opcode -> control bundle; unknown opcodes decode to an all-zero bundle
    function automatic logic [CTRL_W-1:0] decodeCtrl(input logic [5:0] opcode);
        logic [CTRL_W-1:0] ctrl;
        logic [3:0]        aluOp;
        logic [1:0]        wbi;
        logic              isJump, isNotCond, isEq, memWrite, memRead, aluSrc, regDst;
        aluOp     = ALU_ADD;
        wbi       = WB_NONE;
        isJump    = 1'b0;
        isNotCond = 1'b0;
        isEq      = 1'b0;
        memWrite  = 1'b0;
        memRead   = 1'b0;
        aluSrc    = 1'b0;
        regDst    = 1'b0;
        case (opcode)
            OP_RTYPE: begin aluOp = ALU_FUNCT; wbi = WB_ALU; regDst = 1'b1; end
            OP_LW:    begin wbi = WB_MEM; memRead = 1'b1; aluSrc = 1'b1; end
            OP_SW:    begin memWrite = 1'b1; aluSrc = 1'b1; end
            OP_BEQ:   begin aluOp = ALU_SUB; isEq = 1'b1; end
            OP_BNE:   begin aluOp = ALU_SUB; end
            OP_J:     begin isJump = 1'b1; isNotCond = 1'b1; end
            OP_JAL:   begin isJump = 1'b1; isNotCond = 1'b1; wbi = WB_LINK; end
            OP_ADDI:  begin aluOp = ALU_ADD; aluSrc = 1'b1; wbi = WB_ALU; end
            OP_SLTI:  begin aluOp = ALU_SLT; aluSrc = 1'b1; wbi = WB_ALU; end
            OP_ANDI:  begin aluOp = ALU_AND; aluSrc = 1'b1; wbi = WB_ALU; end
            OP_ORI:   begin aluOp = ALU_OR;  aluSrc = 1'b1; wbi = WB_ALU; end
            OP_LUI:   begin aluOp = ALU_LUI; aluSrc = 1'b1; wbi = WB_ALU; end
            default:  begin aluOp = ALU_ADD; end
        endcase
        ctrl = '0;
        ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = aluOp;
        ctrl[CTRL_ISJUMP]                 = isJump;
        ctrl[CTRL_ISNOTCOND]              = isNotCond;
        ctrl[CTRL_ISEQ]                   = isEq;
        ctrl[CTRL_MEMWRITE]               = memWrite;
        ctrl[CTRL_WBI_HI:CTRL_WBI_LO]     = wbi;
        ctrl[CTRL_MEMREAD]                = memRead;
        ctrl[CTRL_ALUSRC]                 = aluSrc;
        ctrl[CTRL_REGDST]                 = regDst;
        return ctrl;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read / one-write register file. r0 reads as zero and ignores writes;
// a same-cycle write to a read address is forwarded to the read port.
module regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wbWe,
    input  logic [$clog2(NREG)-1:0] wbAddr,
    input  logic [DATA_W-1:0]       wbData,
    input  logic [$clog2(NREG)-1:0] raddrA,
    input  logic [$clog2(NREG)-1:0] raddrB,
    output logic [DATA_W-1:0]       rdataA,
    output logic [DATA_W-1:0]       rdataB
);

    logic [DATA_W-1:0] regs [NREG];

    // Storage: reset clears every entry and wins over a concurrent write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wbWe && (wbAddr != '0)) begin
            regs[wbAddr] <= wbData;
        end
    end

    // Read port A with write-first forwarding
    always_comb begin
        rdataA = '0;
        if (raddrA == '0) begin
            rdataA = '0;
        end else if (wbWe && (wbAddr == raddrA)) begin
            rdataA = wbData;
        end else begin
            rdataA = regs[raddrA];
        end
    end

    // Read port B with write-first forwarding
    always_comb begin
        rdataB = '0;
        if (raddrB == '0) begin
            rdataB = '0;
        end else if (wbWe && (wbAddr == raddrB)) begin
            rdataB = wbData;
        end else begin
            rdataB = regs[raddrB];
        end
    end

endmodule

// File: rtl/stage_id_hz.sv
// Instruction-decode stage with ID/EX pipeline register, load-use hazard
// detection (one bubble per hazard) and a saturating bubble counter.
module stage_id_hz
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             instr,
    input  logic [PC_W-1:0]         pc_id,
    input  logic                    valid_in,
    input  logic                    stall_in,
    input  logic                    flush,
    input  logic                    wb_we,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    valid_ex,
    output logic [PC_W-1:0]         pc_ex,
    output logic [CTRL_W-1:0]       ctrl_ex,
    output logic [DATA_W-1:0]       rs_data,
    output logic [DATA_W-1:0]       rt_data,
    output logic [DATA_W-1:0]       imm_ex,
    output logic [$clog2(NREG)-1:0] rs_ex,
    output logic [$clog2(NREG)-1:0] rt_ex,
    output logic [$clog2(NREG)-1:0] rd_ex,
    output logic                    stall_if,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam int AW = $clog2(NREG);

    logic [AW-1:0]     rsAddr, rtAddr, rdAddr;
    logic [DATA_W-1:0] rsRead, rtRead, immExt;
    logic [CTRL_W-1:0] decCtrl;
    logic              hazard;

    logic              validNext;
    logic [PC_W-1:0]   pcNext;
    logic [CTRL_W-1:0] ctrlNext;
    logic [DATA_W-1:0] rsDataNext, rtDataNext, immNext;
    logic [AW-1:0]     rsNext, rtNext, rdNext;
    logic [CNT_W-1:0]  bubbleNext;

    assign rsAddr  = instr[21 +: AW];
    assign rtAddr  = instr[16 +: AW];
    assign rdAddr  = instr[11 +: AW];
    assign immExt  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign decCtrl = decodeCtrl(instr[31:26]);

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) uRegfile (
        .clock  (clock),
        .reset  (reset),
        .wbWe   (wb_we),
        .wbAddr (wb_addr),
        .wbData (wb_data),
        .raddrA (rsAddr),
        .raddrB (rtAddr),
        .rdataA (rsRead),
        .rdataB (rtRead)
    );

    // Load-use detection against the load currently in EX; feeds the IF hold
    always_comb begin
        hazard = 1'b0;
        if (valid_ex && ctrl_ex[CTRL_MEMREAD] && (rt_ex != '0) && valid_in &&
            ((rt_ex == rsAddr) || (rt_ex == rtAddr))) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
        stall_if = hazard || stall_in;
    end

    // ID/EX next values: flush > stall_in (hold) > hazard (bubble) > load
    always_comb begin
        validNext  = valid_ex;
        pcNext     = pc_ex;
        ctrlNext   = ctrl_ex;
        rsDataNext = rs_data;
        rtDataNext = rt_data;
        immNext    = imm_ex;
        rsNext     = rs_ex;
        rtNext     = rt_ex;
        rdNext     = rd_ex;
        bubbleNext = bubble_cnt;
        if (flush) begin
            validNext = 1'b0;
            ctrlNext  = '0;
            pcNext    = '0;
        end else if (stall_in) begin
            validNext = valid_ex;
        end else if (hazard) begin
            validNext = 1'b0;
            ctrlNext  = '0;
            if (bubble_cnt != '1) begin
                bubbleNext = bubble_cnt + CNT_W'(1);
            end else begin
                bubbleNext = bubble_cnt;
            end
        end else begin
            validNext  = valid_in;
            pcNext     = pc_id;
            ctrlNext   = valid_in ? decCtrl : '0;
            rsDataNext = rsRead;
            rtDataNext = rtRead;
            immNext    = immExt;
            rsNext     = rsAddr;
            rtNext     = rtAddr;
            rdNext     = rdAddr;
        end
    end

    // ID/EX pipeline register and bubble counter
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_ex   <= 1'b0;
            pc_ex      <= '0;
            ctrl_ex    <= '0;
            rs_data    <= '0;
            rt_data    <= '0;
            imm_ex     <= '0;
            rs_ex      <= '0;
            rt_ex      <= '0;
            rd_ex      <= '0;
            bubble_cnt <= '0;
        end else begin
            valid_ex   <= validNext;
            pc_ex      <= pcNext;
            ctrl_ex    <= ctrlNext;
            rs_data    <= rsDataNext;
            rt_data    <= rtDataNext;
            imm_ex     <= immNext;
            rs_ex      <= rsNext;
            rt_ex      <= rtNext;
            rd_ex      <= rdNext;
            bubble_cnt <= bubbleNext;
        end
    end

endmodule

// File: tb/tb_stage_id_hz.sv
// Directed bench for stage_id_hz: reset, bypass, r0, load-use bubble,
// downstream stall hold and flush, with hand-computed expectations.
module tb_stage_id_hz;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic        valid_in, stall_in, flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        valid_ex;
    logic [31:0] pc_ex;
    logic [13:0] ctrl_ex;
    logic [31:0] rs_data, rt_data, imm_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic        stall_if;
    logic [15:0] bubble_cnt;

    int totalCnt = 0;
    int badCnt   = 0;

    // Hand-computed control bundles (bit13 rsvd, aluOp 12:9, isJump 8,
    // isNotCond 7, isEq 6, memWrite 5, wbi 4:3, memRead 2, aluSrc 1, regDst 0)
    localparam logic [13:0] C_RTYPE = 14'h1E09;
    localparam logic [13:0] C_LW    = 14'h0016;
    localparam logic [13:0] C_ADDI  = 14'h000A;
    localparam logic [13:0] C_ORI   = 14'h060A;
    localparam logic [13:0] C_BEQ   = 14'h0240;
    localparam logic [13:0] C_J     = 14'h0180;

    stage_id_hz dut (
        .clock      (clock),
        .reset      (reset),
        .instr      (instr),
        .pc_id      (pc_id),
        .valid_in   (valid_in),
        .stall_in   (stall_in),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .valid_ex   (valid_ex),
        .pc_ex      (pc_ex),
        .ctrl_ex    (ctrl_ex),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm_ex     (imm_ex),
        .rs_ex      (rs_ex),
        .rt_ex      (rt_ex),
        .rd_ex      (rd_ex),
        .stall_if   (stall_if),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        if (obs !== exp) begin
            badCnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        reset    = 1'b1;
        instr    = 32'h0;
        pc_id    = 32'h0;
        valid_in = 1'b0;
        stall_in = 1'b0;
        flush    = 1'b0;
        wb_we    = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 32'h1234_5678;

        // Reset with a concurrent write to r5
        tick();
        tick();
        checkEq("rst_valid", valid_ex, 1'b0);
        checkEq("rst_pc", pc_ex, 32'h0);
        checkEq("rst_ctrl", ctrl_ex, 14'h0);
        checkEq("rst_bubble", bubble_cnt, 16'h0);
        checkEq("rst_stall_if", stall_if, 1'b0);

        reset    = 1'b0;
        wb_we    = 1'b0;
        instr    = mkI(6'h08, 5'd5, 5'd0, 16'h0000);
        pc_id    = 32'h0000_0010;
        valid_in = 1'b1;
        #1;
        checkEq("post_rst_stall_if", stall_if, 1'b0);
        tick();
        checkEq("r5_after_rst", rs_data, 32'h0);
        checkEq("r5_bubble", bubble_cnt, 16'h0);
        checkEq("addi_ctrl", ctrl_ex, C_ADDI);

        // Write-first bypass on r3 while add r6 = r3 + r4 is decoded
        wb_we   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hDEAD_BEEF;
        instr   = mkR(5'd3, 5'd4, 5'd6, 6'h20);
        pc_id   = 32'h0000_0100;
        tick();
        checkEq("bypass_rs", rs_data, 32'hDEAD_BEEF);
        checkEq("bypass_rt", rt_data, 32'h0);
        checkEq("add_valid", valid_ex, 1'b1);
        checkEq("add_pc", pc_ex, 32'h0000_0100);
        checkEq("add_ctrl", ctrl_ex, C_RTYPE);
        checkEq("add_regs", {rs_ex, rt_ex, rd_ex}, {5'd3, 5'd4, 5'd6});
        checkEq("add_imm", imm_ex, 32'h0000_3020);

        // Write to r0 is dropped; r3 now read from storage
        wb_addr = 5'd0;
        wb_data = 32'h0000_FFFF;
        instr   = mkI(6'h0D, 5'd0, 5'd3, 16'hFFFF);
        pc_id   = 32'h0000_0104;
        tick();
        checkEq("r0_bypass", rs_data, 32'h0);
        checkEq("r3_stored", rt_data, 32'hDEAD_BEEF);
        checkEq("ori_ctrl", ctrl_ex, C_ORI);
        checkEq("ori_imm_sext", imm_ex, 32'hFFFF_FFFF);
        wb_we = 1'b0;
        tick();
        checkEq("r0_read", rs_data, 32'h0);

        // Load-use: lw r4,8(r3) then add r7 = r4 + r3
        instr = mkI(6'h23, 5'd3, 5'd4, 16'h0008);
        pc_id = 32'h0000_0200;
        tick();
        checkEq("lw_ctrl", ctrl_ex, C_LW);
        checkEq("lw_rt", rt_ex, 5'd4);
        instr = mkR(5'd4, 5'd3, 5'd7, 6'h20);
        pc_id = 32'h0000_0204;
        #1;
        checkEq("lu_stall_if", stall_if, 1'b1);
        tick();
        checkEq("bubble_valid", valid_ex, 1'b0);
        checkEq("bubble_ctrl", ctrl_ex, 14'h0);
        checkEq("bubble_cnt1", bubble_cnt, 16'h1);
        checkEq("bubble_stall_if", stall_if, 1'b0);
        tick();
        checkEq("issue_valid", valid_ex, 1'b1);
        checkEq("issue_pc", pc_ex, 32'h0000_0204);
        checkEq("issue_ctrl", ctrl_ex, C_RTYPE);
        checkEq("issue_rs", rs_ex, 5'd4);
        checkEq("issue_cnt", bubble_cnt, 16'h1);

        // Load followed by an invalid slot using r4: no hazard, ctrl forced 0
        instr = mkI(6'h23, 5'd3, 5'd4, 16'h0008);
        pc_id = 32'h0000_0208;
        tick();
        instr    = mkR(5'd4, 5'd4, 5'd8, 6'h20);
        valid_in = 1'b0;
        #1;
        checkEq("inv_stall_if", stall_if, 1'b0);
        tick();
        checkEq("inv_valid", valid_ex, 1'b0);
        checkEq("inv_ctrl", ctrl_ex, 14'h0);
        checkEq("inv_cnt", bubble_cnt, 16'h1);

        // Load into r0 followed by a use of r0: no hazard
        valid_in = 1'b1;
        instr    = mkI(6'h23, 5'd3, 5'd0, 16'h0000);
        tick();
        instr = mkR(5'd0, 5'd0, 5'd9, 6'h20);
        #1;
        checkEq("r0_load_stall_if", stall_if, 1'b0);

        // Downstream stall: hold outputs for 3 cycles, write r9 meanwhile
        instr = mkI(6'h08, 5'd1, 5'd2, 16'h0005);
        pc_id = 32'h0000_0300;
        tick();
        stall_in = 1'b1;
        wb_we    = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'h0000_A5A5;
        for (int i = 0; i < 3; i++) begin
            instr = mkI(6'h04 + 6'(i), 5'd10 + 5'(i), 5'd11, 16'h1000 + 16'(i));
            pc_id = 32'h0000_0304 + 32'(4 * i);
            #1;
            checkEq("hold_stall_if", stall_if, 1'b1);
            tick();
            checkEq("hold_pc", pc_ex, 32'h0000_0300);
            checkEq("hold_ctrl", ctrl_ex, C_ADDI);
            checkEq("hold_imm", imm_ex, 32'h0000_0005);
            checkEq("hold_valid", valid_ex, 1'b1);
        end
        stall_in = 1'b0;
        wb_we    = 1'b0;
        instr    = mkI(6'h04, 5'd9, 5'd0, 16'hFFFF);
        pc_id    = 32'h0000_0310;
        tick();
        checkEq("beq_ctrl", ctrl_ex, C_BEQ);
        checkEq("r9_written_in_stall", rs_data, 32'h0000_A5A5);
        checkEq("beq_imm", imm_ex, 32'hFFFF_FFFF);

        // Flush together with stall
        flush    = 1'b1;
        stall_in = 1'b1;
        instr    = mkI(6'h02, 5'd0, 5'd0, 16'h0040);
        pc_id    = 32'h0000_0320;
        tick();
        checkEq("flush_valid", valid_ex, 1'b0);
        checkEq("flush_ctrl", ctrl_ex, 14'h0);
        checkEq("flush_pc", pc_ex, 32'h0);
        flush    = 1'b0;
        stall_in = 1'b0;
        pc_id    = 32'h0000_0324;
        tick();
        checkEq("j_ctrl", ctrl_ex, C_J);
        checkEq("j_pc", pc_ex, 32'h0000_0324);
        checkEq("final_cnt", bubble_cnt, 16'h1);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/stage_id_hz.md
STAGE_ID_HZ -- requirements
Module: stage_id_hz

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/operand width.
REQ-002 SHALL have parameter NREG, default 32, register-file depth (power of 2, 8..32).
REQ-003 SHALL have parameter PC_W, default 32, program-counter width.
REQ-004 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-005 SHALL have ports: clock  in  1  rising-edge clock; reset  in  1  sync active-high reset.
REQ-006 SHALL have ports: instr in 32 IF/ID instruction; pc_id in PC_W; valid_in in 1 IF slot valid; stall_in in 1 downstream hold; flush in 1 branch/jump squash.
REQ-007 SHALL have ports: wb_we in 1; wb_addr in log2(NREG); wb_data in DATA_W (write-back).
REQ-008 SHALL have outputs: valid_ex 1; pc_ex PC_W; ctrl_ex CTRL_W; rs_data, rt_data DATA_W; imm_ex DATA_W; rs_ex, rt_ex, rd_ex log2(NREG); stall_if 1 (hold IF/PC); bubble_cnt CNT_W.

Function
REQ-009 SHALL decode instr[31:26] combinationally into ctrl bundle {aluOp[3:0], isJump, isNotConditional, isEq, memWrite, wbi[1:0], memRead, aluSrc, regDst}, CTRL_W=14.
REQ-010 SHALL sign-extend instr[15:0] to DATA_W for imm_ex.
REQ-011 SHALL read rs=instr[25:21], rt=instr[20:16] (low log2(NREG) bits) from internal register file, NREG x DATA_W.
REQ-012 SHALL return 0 for register 0; writes to register 0 ignored.
REQ-013 SHALL write-first bypass: wb_we && wb_addr==read addr && addr!=0 -> read returns wb_data same cycle.
REQ-014 SHALL register all ID/EX outputs on rising edge; latency one cycle from instr to valid_ex.
REQ-015 SHALL detect load-use: valid_ex && ctrl_ex.memRead && rt_ex!=0 && valid_in && (rt_ex==rs or rt_ex==rt) -> hazard.
REQ-016 SHALL drive stall_if combinationally = hazard || stall_in.
REQ-017 SHALL, on hazard (no flush, no stall_in), load bubble: valid_ex=0, ctrl_ex=0; other fields don't-care; exactly one bubble per load-use.
REQ-018 SHALL, on stall_in (no flush), hold every ID/EX output; hazard not evaluated into bubble.
REQ-019 SHALL, on flush, load valid_ex=0, ctrl_ex=0, pc_ex=0 regardless of stall_in/hazard.
REQ-020 SHALL otherwise load decoded fields; valid_ex=valid_in; ctrl_ex forced 0 if valid_in=0.
REQ-021 SHALL priority: reset > flush > stall_in > hazard > load.
REQ-022 SHALL perform register-file writes whenever wb_we=1, independent of stall_in/flush/hazard.
REQ-023 SHALL increment bubble_cnt on each hazard bubble, saturating at all-ones.

Reset
REQ-024 SHALL, on reset, clear all NREG registers, valid_ex, pc_ex, ctrl_ex, imm_ex, rs_data, rt_data, rs_ex, rt_ex, rd_ex, bubble_cnt to 0.
REQ-025 SHALL give reset priority over wb_we in the same cycle (register written stays 0).
REQ-026 SHALL hold stall_if=0 during and one cycle after reset (valid_ex=0 guarantees this).

Structure
REQ-027 SHALL place opcode constants, ctrl bundle field offsets and CTRL_W in shared package mips_pkg.
REQ-028 SHALL implement register file as sub-module regfile_bypass (parameters DATA_W, NREG).
REQ-029 SHALL keep decoder as combinational function in mips_pkg, not a module.

Verification
REQ-030 Reset with wb_we=1, wb_addr=5 -> after release reading r5 returns 0, bubble_cnt=0.
REQ-031 wb_we=1, wb_addr=3, wb_data=0xDEADBEEF while instr reads rs=3 -> next cycle rs_data=0xDEADBEEF.
REQ-032 lw r4 (op 0x23) then add rs=4 -> stall_if=1 one cycle, one bubble valid_ex=0, add issues next cycle, bubble_cnt=1.
REQ-033 stall_in=1 for 3 cycles with changing instr -> outputs constant, stall_if=1 throughout.
REQ-034 flush=1 and stall_in=1 same cycle -> valid_ex=0, ctrl_ex=0, pc_ex=0.
REQ-035 Write wb_addr=0 data 0xFFFF -> read r0 returns 0.
